// File: rtl/modulo_disp.sv
// Seven-segment note decoder: {tonality, note} -> registered glyph for a single digit.
// Major tonality shows uppercase-style glyphs, minor shows lowercase-style glyphs.
module modulo_disp #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TOM_module,
    input  logic [2:0] NOTAS,
    output logic [6:0] SAIDA
);

    logic [6:0] w_glyph;
    logic [6:0] w_drive;
    logic [6:0] w_blank;
    logic [6:0] r_saida;

    // Glyphs are stored lit-high in {a,b,c,d,e,f,g} order; polarity is applied afterwards.
    always_comb begin
        w_glyph = 7'b0000000;
        case ({TOM_module, NOTAS})
            4'b0_000: w_glyph = 7'b0000000;
            4'b0_001: w_glyph = 7'b1001110;
            4'b0_010: w_glyph = 7'b0111101;
            4'b0_011: w_glyph = 7'b1001111;
            4'b0_100: w_glyph = 7'b1000111;
            4'b0_101: w_glyph = 7'b1011110;
            4'b0_110: w_glyph = 7'b1110111;
            4'b0_111: w_glyph = 7'b1111111;
            4'b1_000: w_glyph = 7'b0000000;
            4'b1_001: w_glyph = 7'b0001101;
            4'b1_010: w_glyph = 7'b0111101;
            4'b1_011: w_glyph = 7'b1101111;
            4'b1_100: w_glyph = 7'b1000111;
            4'b1_101: w_glyph = 7'b1111011;
            4'b1_110: w_glyph = 7'b1111101;
            4'b1_111: w_glyph = 7'b0011111;
            default:  w_glyph = 7'b0000000;
        endcase
    end

    assign w_drive = ACTIVE_LOW ? ~w_glyph : w_glyph;
    assign w_blank = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_saida <= w_blank;
        end else begin
            r_saida <= w_drive;
        end
    end

    assign SAIDA = r_saida;

endmodule

// File: tb/tb_modulo_disp.sv
// Directed bench for modulo_disp: drives both polarities from shared inputs and checks
// each registered glyph against hand-computed table values.
module tb_modulo_disp;

    logic       clk;
    logic       rst;
    logic       tom;
    logic [2:0] notas;
    logic [6:0] saida_hi;
    logic [6:0] saida_lo;

    int n_tests;
    int n_fail;

    typedef struct {
        logic       rst;
        logic       tom;
        logic [2:0] notas;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    modulo_disp #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk        (clk),
        .rst        (rst),
        .TOM_module (tom),
        .NOTAS      (notas),
        .SAIDA      (saida_hi)
    );

    modulo_disp #(.ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk        (clk),
        .rst        (rst),
        .TOM_module (tom),
        .NOTAS      (notas),
        .SAIDA      (saida_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Expected values are given for the lit-high instance; the inverted instance must be ~exp.
    task automatic check_both(input string name, input logic [6:0] exp);
        check({name, " hi"}, saida_hi, exp);
        check({name, " lo"}, saida_lo, ~exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic t, input logic [2:0] n,
                       input logic [6:0] e, input string name);
        vec_t v;
        v.rst   = r;
        v.tom   = t;
        v.notas = n;
        v.exp   = e;
        v.name  = name;
        vecs.push_back(v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        tom     = 1'b1;
        notas   = 3'b111;

        // Reset with inputs pointing at "b", then release.
        add(1'b1, 1'b1, 3'b111, 7'b0000000, "reset0");
        add(1'b1, 1'b1, 3'b111, 7'b0000000, "reset1");
        add(1'b0, 1'b1, 3'b111, 7'b0011111, "release_b");
        // Major sweep.
        add(1'b0, 1'b0, 3'b000, 7'b0000000, "maj_rest");
        add(1'b0, 1'b0, 3'b001, 7'b1001110, "maj_C");
        add(1'b0, 1'b0, 3'b010, 7'b0111101, "maj_D");
        add(1'b0, 1'b0, 3'b011, 7'b1001111, "maj_E");
        add(1'b0, 1'b0, 3'b100, 7'b1000111, "maj_F");
        add(1'b0, 1'b0, 3'b101, 7'b1011110, "maj_G");
        add(1'b0, 1'b0, 3'b110, 7'b1110111, "maj_A");
        add(1'b0, 1'b0, 3'b111, 7'b1111111, "maj_B");
        // Minor sweep.
        add(1'b0, 1'b1, 3'b000, 7'b0000000, "min_rest");
        add(1'b0, 1'b1, 3'b001, 7'b0001101, "min_c");
        add(1'b0, 1'b1, 3'b010, 7'b0111101, "min_d");
        add(1'b0, 1'b1, 3'b011, 7'b1101111, "min_e");
        add(1'b0, 1'b1, 3'b100, 7'b1000111, "min_F");
        add(1'b0, 1'b1, 3'b101, 7'b1111011, "min_g");
        add(1'b0, 1'b1, 3'b110, 7'b1111101, "min_a");
        add(1'b0, 1'b1, 3'b111, 7'b0011111, "min_b");
        // Major sweep with a one-cycle reset at G; reset wins over decode.
        add(1'b0, 1'b0, 3'b011, 7'b1001111, "mid_E");
        add(1'b0, 1'b0, 3'b100, 7'b1000111, "mid_F");
        add(1'b1, 1'b0, 3'b101, 7'b0000000, "mid_rst_G");
        add(1'b0, 1'b0, 3'b110, 7'b1110111, "mid_A");
        add(1'b0, 1'b0, 3'b111, 7'b1111111, "mid_B");

        foreach (vecs[i]) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            tom   = vecs[i].tom;
            notas = vecs[i].notas;
            tick();
            check_both(vecs[i].name, vecs[i].exp);
        end

        // Tonality toggle on held A: output must not move until the edge after each change.
        @(negedge clk);
        rst   = 1'b0;
        notas = 3'b110;
        tom   = 1'b0;
        tick();
        check_both("tog_A0", 7'b1110111);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tom = ~tom;
            #1;
            check_both("tog_hold", (tom ? 7'b1110111 : 7'b1111101));
            tick();
            check_both("tog_new", (tom ? 7'b1111101 : 7'b1110111));
        end

        // Glitch between edges is not sampled.
        @(negedge clk);
        tom   = 1'b0;
        notas = 3'b001;
        tick();
        check_both("pre_glitch_C", 7'b1001110);
        #2;
        notas = 3'b111;
        tom   = 1'b1;
        #2;
        notas = 3'b001;
        tom   = 1'b0;
        tick();
        check_both("post_glitch_C", 7'b1001110);

        // Reset asserted then held: blank persists; first low edge loads decode.
        @(negedge clk);
        rst   = 1'b1;
        tom   = 1'b1;
        notas = 3'b011;
        tick();
        check_both("hold_rst", 7'b0000000);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_both("after_rst_e", 7'b1101111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety bound so a stalled run still terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
